// File: rtl/esp32_spi_slave.sv
// esp32_spi_slave: mode-0 SPI slave (CPOL=0/CPHA=0, MSB first, 8-bit bytes) for the ESP32.
// SCLK/MOSI/SS_n are oversampled in the clk_clk domain. Received bytes are presented on a
// ready/valid stream. MISO bytes come from a single-entry ready/valid holding register.
// Ports:
//   clk_clk, reset_reset            system clock, synchronous active-high reset
//   esp32_spi_SCLK/MOSI/SS_n        asynchronous SPI inputs from the ESP32
//   esp32_spi_MISO                  registered slave-out data (1 when not selected)
//   rx_data/rx_valid/rx_ready       received-byte stream
//   tx_data/tx_valid/tx_ready       holding-register write port for MISO bytes
//   rx_overrun/overrun_clr          sticky dropped-byte flag and its clear pulse
//   busy                            frame in progress
module esp32_spi_slave #(
   parameter logic [7:0] FILL_BYTE = 8'hFF
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       esp32_spi_SCLK,
   input  logic       esp32_spi_MOSI,
   input  logic       esp32_spi_SS_n,
   output logic       esp32_spi_MISO,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       rx_overrun,
   input  logic       overrun_clr,
   output logic       busy
);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

   state_t     state;
   logic       sclk_s1, sclk_s2, sclk_s3;
   logic       mosi_s1, mosi_s2;
   logic       ss_s1, ss_s2, ss_s3;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   logic [7:0] tx_shift;
   logic [7:0] tx_hold;

   logic       sclk_rise, sclk_fall, ss_fall;
   logic       byte_done, tx_load;
   logic [7:0] rx_byte, load_byte;

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign sclk_fall = ~sclk_s2 & sclk_s3;
   assign ss_fall   = ~ss_s2 & ss_s3;

   // Eighth rising edge of a byte while still selected
   assign byte_done = (state == ACTIVE) && !ss_s2 && sclk_rise && (bit_cnt == 3'd7);
   assign tx_load   = ((state == IDLE) && ss_fall) || byte_done;
   assign rx_byte   = {rx_shift, mosi_s2};
   // tx_ready doubles as the "holding register empty" flag
   assign load_byte = tx_ready ? FILL_BYTE : tx_hold;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state          <= WAIT_IDLE;
         sclk_s1        <= 1'b0;
         sclk_s2        <= 1'b0;
         sclk_s3        <= 1'b0;
         mosi_s1        <= 1'b0;
         mosi_s2        <= 1'b0;
         ss_s1          <= 1'b1;
         ss_s2          <= 1'b1;
         // History flop resets low so WAIT_IDLE cannot mistake the reset value of the
         // synchroniser for a genuinely deselected bus.
         ss_s3          <= 1'b0;
         bit_cnt        <= 3'd0;
         rx_shift       <= 7'd0;
         tx_shift       <= 8'd0;
         tx_hold        <= 8'd0;
         esp32_spi_MISO <= 1'b1;
         rx_data        <= 8'd0;
         rx_valid       <= 1'b0;
         tx_ready       <= 1'b1;
         rx_overrun     <= 1'b0;
         busy           <= 1'b0;
      end else begin
         // Synchronisers and edge-detect history
         sclk_s1 <= esp32_spi_SCLK;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         mosi_s1 <= esp32_spi_MOSI;
         mosi_s2 <= mosi_s1;
         ss_s1   <= esp32_spi_SS_n;
         ss_s2   <= ss_s1;
         ss_s3   <= ss_s2;

         // Holding register: a load empties it; a write in the same cycle refills it afterwards
         if (tx_load) begin
            tx_ready <= 1'b1;
         end
         if (tx_valid && tx_ready) begin
            tx_hold  <= tx_data;
            tx_ready <= 1'b0;
         end

         // Byte delivery; a set of the overrun flag overrides a simultaneous clear
         if (overrun_clr) begin
            rx_overrun <= 1'b0;
         end
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= rx_byte;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            WAIT_IDLE: begin
               esp32_spi_MISO <= 1'b1;
               // Wait for a deselect seen through the whole synchroniser chain
               if (ss_s1 && ss_s2 && ss_s3) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               esp32_spi_MISO <= 1'b1;
               bit_cnt        <= 3'd0;
               if (ss_fall) begin
                  tx_shift       <= load_byte;
                  esp32_spi_MISO <= load_byte[7];
                  busy           <= 1'b1;
                  state          <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (ss_s2) begin
                  // Deselect: partial byte and loaded TX byte are discarded
                  state          <= IDLE;
                  busy           <= 1'b0;
                  bit_cnt        <= 3'd0;
                  esp32_spi_MISO <= 1'b1;
               end else begin
                  if (sclk_rise) begin
                     rx_shift <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        tx_shift <= load_byte;
                     end
                  end
                  if (sclk_fall) begin
                     esp32_spi_MISO <= tx_shift[3'd7 - bit_cnt];
                  end
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

endmodule
